// File: rtl/sha0_msg_streamer.sv
// sha0_msg_streamer: buffers a host message and streams it to the SHA-0 core.
// Optional WAIT watchdog enabled by SHA0_STREAM_TIMEOUT_EN.
module sha0_msg_streamer #(
  parameter int MAX_BYTES      = 64,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int AW = $clog2(MAX_BYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             go,
  input  logic [LEN_W-1:0] len,
  output logic             idle,
  output logic             done,
  output logic             err_len,
  output logic             timeout,
  output logic [159:0]     result,
  output logic             result_valid,
  output logic             start,
  output logic [LEN_W-1:0] msg_len,
  output logic             in_valid,
  output logic [7:0]       in_data,
  input  logic             in_ready,
  input  logic             core_busy,
  input  logic             digest_valid,
  input  logic [31:0]      digest0,
  input  logic [31:0]      digest1,
  input  logic [31:0]      digest2,
  input  logic [31:0]      digest3,
  input  logic [31:0]      digest4
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [159:0]     res_q, res_d;
  logic             rv_q, rv_d;
  logic             err_q, err_d;
  logic [7:0]       mem_q [MAX_BYTES];
  logic             len_ok;
  logic             last;
  logic             unused_ok;

`ifdef SHA0_STREAM_TIMEOUT_EN
  logic [31:0]      cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  assign len_ok = (len <= LEN_W'(MAX_BYTES));
  assign last   = (LEN_W'(ptr_q) + LEN_W'(1)) == len_q;

  assign unused_ok = &{1'b0, core_busy,
                       (TIMEOUT_CYCLES != 0)};

  // buffer is writable only while idle; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE)
      mem_q[wr_addr] <= wr_data;
  end

  // state and datapath registers, async active-high reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef SHA0_STREAM_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
`ifdef SHA0_STREAM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // next-state and register update logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    res_d   = res_q;
    rv_d    = rv_q;
    err_d   = 1'b0;
`ifdef SHA0_STREAM_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          if (len_ok) begin
            len_d   = len;
            ptr_d   = '0;
            rv_d    = 1'b0;
            state_d = S_START;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      S_START: begin
        state_d = (len_q == '0) ? S_WAIT
                                : S_STREAM;
`ifdef SHA0_STREAM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_STREAM: begin
        if (in_ready) begin
          ptr_d = ptr_q + {{AW{1'b0}}, 1'b1};
          if (last) begin
            state_d = S_WAIT;
`ifdef SHA0_STREAM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (digest_valid) begin
          res_d   = {digest0, digest1, digest2,
                     digest3, digest4};
          rv_d    = 1'b1;
          state_d = S_DONE;
        end
`ifdef SHA0_STREAM_TIMEOUT_EN
        else if (cnt_q ==
                 32'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 32'd1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign idle         = (state_q == S_IDLE);
  assign start        = (state_q == S_START);
  assign in_valid     = (state_q == S_STREAM);
  assign done         = (state_q == S_DONE);
  assign in_data      = in_valid ?
                        mem_q[ptr_q[AW-1:0]] : 8'h00;
  assign err_len      = err_q;
  assign msg_len      = len_q;
  assign result       = res_q;
  assign result_valid = rv_q;
`ifdef SHA0_STREAM_TIMEOUT_EN
  assign timeout      = to_q;
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_sha0_msg_streamer.sv
// tb_sha0_msg_streamer: directed bench with a behavioural SHA-0 core.
// Timeout checks run when SHA0_STREAM_TIMEOUT_EN is defined.
module tb_sha0_msg_streamer;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic [5:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         go;
  logic [15:0]  len;
  logic         idle, done, err_len, timeout;
  logic [159:0] result;
  logic         result_valid, start;
  logic [15:0]  msg_len;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready     = 1'b1;
  logic         core_busy    = 1'b0;
  logic         digest_valid = 1'b0;
  logic [31:0]  digest0 = '0, digest1 = '0, digest2 = '0;
  logic [31:0]  digest3 = '0, digest4 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  bit tog      = 1'b0;
  bit suppress = 1'b0;
  int spur_req = 0;

  int         nstart     = 0;
  int         nxfer      = 0;
  int         mlen       = 0;
  int         stall_bad  = 0;
  int         stall_seen = 0;
  int         to_seen    = 0;
  bit         stall_prev = 1'b0;
  logic [7:0] held       = '0;
  logic [7:0] got[$];

  int served    = 0;
  int dly       = 0;
  int spur_done = 0;

  sha0_msg_streamer #(
    .MAX_BYTES      (64),
    .LEN_W          (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .go           (go),
    .len          (len),
    .idle         (idle),
    .done         (done),
    .err_len      (err_len),
    .timeout      (timeout),
    .result       (result),
    .result_valid (result_valid),
    .start        (start),
    .msg_len      (msg_len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .core_busy    (core_busy),
    .digest_valid (digest_valid),
    .digest0      (digest0),
    .digest1      (digest1),
    .digest2      (digest2),
    .digest3      (digest3),
    .digest4      (digest4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [159:0] obs,
                       input logic [159:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] sha0(input logic [7:0] m[$]);
    logic [7:0]  p[$];
    logic [31:0] h[5];
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, t;
    logic [63:0] bl;
    p  = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
    h[0] = 32'h67452301; h[1] = 32'hEFCDAB89;
    h[2] = 32'h98BADCFE; h[3] = 32'h10325476;
    h[4] = 32'hC3D2E1F0;
    for (int blk = 0; blk < p.size() / 64; blk++) begin
      for (int i = 0; i < 16; i++)
        w[i] = {p[blk*64+4*i], p[blk*64+4*i+1],
                p[blk*64+4*i+2], p[blk*64+4*i+3]};
      for (int i = 16; i < 80; i++)
        w[i] = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
      for (int i = 0; i < 80; i++) begin
        if (i < 20) begin
          f = (b & c) | (~b & d); k = 32'h5A827999;
        end else if (i < 40) begin
          f = b ^ c ^ d; k = 32'h6ED9EBA1;
        end else if (i < 60) begin
          f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
        end else begin
          f = b ^ c ^ d; k = 32'hCA62C1D6;
        end
        t = {a[26:0], a[31:27]} + f + e + k + w[i];
        e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e;
    end
    return {h[0], h[1], h[2], h[3], h[4]};
  endfunction

  // core-side observer: handshakes, start pulses, stall stability
  always @(posedge clk) begin
    if (stall_prev && in_valid && in_data !== held)
      stall_bad++;
    stall_prev = in_valid && !in_ready && !rst_n;
    if (stall_prev) stall_seen++;
    held = in_data;
    if (timeout) to_seen++;
    if (start) begin
      nstart++;
      got.delete();
      mlen = int'(msg_len);
    end
    if (in_valid && in_ready) begin
      got.push_back(in_data);
      nxfer++;
    end
  end

  // core-side driver: ready pattern and digest delivery
  always @(negedge clk) begin
    in_ready     = tog ? ~in_ready : 1'b1;
    digest_valid = 1'b0;
    core_busy    = (served != nstart);
    if (spur_done != spur_req) begin
      digest_valid = 1'b1;
      {digest0, digest1, digest2, digest3, digest4}
        = {5{32'hDEADBEEF}};
      spur_done = spur_req;
    end else if (!suppress && served != nstart &&
                 got.size() == mlen) begin
      dly++;
      if (dly == 3) begin
        digest_valid = 1'b1;
        {digest0, digest1, digest2, digest3, digest4}
          = sha0(got);
        served = nstart;
        dly    = 0;
      end
    end else begin
      dly = 0;
    end
  end

  task automatic load(input string msg, input int l);
    for (int i = 0; i < l; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 6'(i);
      wr_data = msg[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_job(input string tag, input string msg,
                         input int l, input bit toggle,
                         input logic [159:0] exp);
    int s0, x0;
    bit seen;
    load(msg, l);
    tog = toggle;
    s0  = nstart;
    x0  = nxfer;
    @(negedge clk);
    go  = 1'b1;
    len = 16'(l);
    @(negedge clk);
    go  = 1'b0;
    check({tag, "_start"}, start, 1'b1);
    check({tag, "_rv_clr"}, result_valid, 1'b0);
    @(negedge clk);
    check({tag, "_iv_lat"}, in_valid, l > 0);
    if (l > 0) begin
      wr_en   = 1'b1;
      wr_addr = 6'(l - 1);
      wr_data = ~msg[l-1];
    end
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, seen, 1'b1);
    check({tag, "_result"}, result, exp);
    check({tag, "_rv"}, result_valid, 1'b1);
    check({tag, "_nstart"}, nstart - s0, 1);
    check({tag, "_nxfer"}, nxfer - x0, l);
    check({tag, "_msglen"}, msg_len, l);
    @(negedge clk);
    check({tag, "_done_end"}, {done, idle}, 2'b01);
    tog = 1'b0;
  endtask

  initial begin
    string      alpha, s64;
    logic [7:0] q64[$];
    int         s0, x0, sb0, ss0, k, nd;
    logic [159:0] exp64;

    rst_n   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    go      = 1'b0;
    len     = '0;
    alpha   = "abcdefghijklmnopqrstuvwxyz";
    s64     = {"0123456789abcdefghijklmnopqrstuvwxyz",
               "ABCDEFGHIJKLMNOPQRSTUVWXYZ!?"};

    repeat (3) @(negedge clk);
    check("rst_idle", idle, 1'b1);
    check("rst_ctl",
          {done, err_len, timeout, start, in_valid, result_valid},
          6'b0);
    check("rst_res", result, '0);
    check("rst_len", {msg_len, in_data}, '0);
    rst_n = 1'b0;
    @(negedge clk);

    run_job("abc", "abc", 3, 1'b0,
            160'h0164b8a9_14cd2a5e_74c4f7ff_082c4d97_f1edf880);
    run_job("empty", "", 0, 1'b0,
            160'hf96cea19_8ad1dd56_17ac084a_3d92c610_7708c0ef);

    sb0 = stall_bad;
    ss0 = stall_seen;
    run_job("alpha", alpha, 26, 1'b1,
            160'hb40ce07a_430cfd3c_033039b9_fe9afec9_5dc1bdcd);
    check("stall_hold", stall_bad - sb0, 0);
    check("stall_seen", stall_seen > ss0, 1'b1);

    s0 = nstart;
    @(negedge clk);
    go  = 1'b1;
    len = 16'd65;
    @(negedge clk);
    go  = 1'b0;
    check("err_pulse", {err_len, start, idle}, 3'b101);
    check("err_rv_hold", result_valid, 1'b1);
    @(negedge clk);
    check("err_end", {err_len, start, idle}, 3'b001);
    check("err_nstart", nstart - s0, 0);

    run_job("msgdig", "message digest", 14, 1'b0,
            160'hc1b0f222_d150ebb9_aa36a40c_afdc8bcb_ed830b14);

    for (int i = 0; i < 64; i++) q64.push_back(s64[i]);
    exp64 = sha0(q64);
    run_job("len64", s64, 64, 1'b1, exp64);

    load(alpha, 26);
    x0 = nxfer;
    @(negedge clk);
    go  = 1'b1;
    len = 16'd26;
    @(negedge clk);
    go  = 1'b0;
    k   = 0;
    while (nxfer - x0 < 10 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("abort_at10", nxfer - x0, 10);
    rst_n = 1'b1;
    #1;
    check("abort_idle", idle, 1'b1);
    check("abort_ctl",
          {done, err_len, timeout, start, in_valid, result_valid},
          6'b0);
    check("abort_res", result, '0);
    check("abort_len", {msg_len, in_data}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_nodone", nd, 0);
    check("abort_nxfer", nxfer - x0, 10);

    run_job("rerun", "abcdbcdecdefdefgefghfghigh", 26, 1'b0,
            160'h5b96da10_eafa22e3_7bdd6ffd_8c77920e_bcb75c29);

    spur_req++;
    k = 0;
    while (spur_done != spur_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check("spur_res", result,
          160'h5b96da10_eafa22e3_7bdd6ffd_8c77920e_bcb75c29);
    check("spur_state", {result_valid, idle, done}, 3'b110);

`ifdef SHA0_STREAM_TIMEOUT_EN
    suppress = 1'b1;
    @(negedge clk);
    go  = 1'b1;
    len = 16'd0;
    @(negedge clk);
    go  = 1'b0;
    check("to_start", start, 1'b1);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      k++;
      if (timeout) break;
    end
    check("to_delay", k, 17);
    check("to_state", {timeout, idle, result_valid, done},
          4'b1100);
    @(negedge clk);
    check("to_pulse", {timeout, idle}, 2'b01);
`else
    check("to_tied", timeout, 1'b0);
    check("to_never", to_seen, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
